ram_arbiter: RTL and testbench
==============================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL have parameter HOLD_MAX, default 4: max consecutive cycles m1 may be denied while requesting; legal range 1..15.
REQ-002 SHALL have port clk, input, 1: clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, asynchronous, active-high.
REQ-004 SHALL have port m0_req, input, 1: requester 0 (CPU data port) access request.
REQ-005 SHALL have port m0_addr, input, 32: requester 0 byte address.
REQ-006 SHALL have port m0_wdata, input, 32: requester 0 write data.
REQ-007 SHALL have port m0_wen, input, 4: requester 0 byte write enables; 0 = read.
REQ-008 SHALL have port m0_gnt, output, 1: requester 0 access accepted this cycle.
REQ-009 SHALL have port m0_rvalid, output, 1: requester 0 response valid.
REQ-010 SHALL have port m0_rdata, output, 32: requester 0 read data.
REQ-011 SHALL have ports m1_req, m1_addr, m1_wdata, m1_wen, m1_gnt, m1_rvalid, m1_rdata with the same directions, widths and meanings for requester 1 (loader/debug).
REQ-012 SHALL have port ram_addr, output, 32: shared RAM address.
REQ-013 SHALL have port ram_wdata, output, 32: shared RAM write data.
REQ-014 SHALL have port ram_wen, output, 4: shared RAM byte enables.
REQ-015 SHALL have port ram_rdata, input, 32: shared RAM combinational read data.

Function
REQ-016 At most one of m0_gnt/m1_gnt SHALL be high in any cycle; grant is combinational, same cycle as req.
REQ-017 Default priority SHALL be m0; m1 SHALL be granted when m0_req=0, or when wait_cnt==HOLD_MAX and m1_req=1 (forced slot).
REQ-018 wait_cnt SHALL increment each edge where m1_req=1 and m1_gnt=0, saturate at HOLD_MAX, and clear on any m1 grant or when m1_req=0.
REQ-019 Granted master's addr/wdata/wen SHALL drive ram_*; with no grant ram_addr=0, ram_wdata=0, ram_wen=0.
REQ-020 A write SHALL commit at the edge ending the granted cycle; no write SHALL occur for an ungranted requester.
REQ-021 mX_rvalid SHALL pulse high exactly one cycle after every mX grant (read or write); latency 1.
REQ-022 mX_rdata SHALL register ram_rdata at the edge ending an mX read grant and hold until the next mX read grant; writes leave mX_rdata unchanged.
REQ-023 Dropping req while waiting SHALL cancel it with no side effects; requesters hold addr/wdata/wen stable until gnt.
REQ-024 Both requesting with wait_cnt<HOLD_MAX SHALL grant m0; at wait_cnt==HOLD_MAX SHALL grant m1 for exactly one cycle, then revert to m0 priority.

Reset
REQ-025 While rst_n=1, all gnt outputs and ram_wen SHALL be 0 combinationally, so no write commits during reset.
REQ-026 Reset SHALL clear wait_cnt, m0_rvalid, m1_rvalid to 0 and m0_rdata, m1_rdata to 32'h0.
REQ-027 Reset mid-access SHALL abort it; no rvalid SHALL follow for the aborted access.

Structure
REQ-028 Shared package ram_arb_pkg SHALL hold the grant-select encoding (SEL_NONE, SEL_M0, SEL_M1) and the HOLD_MAX range limit.
REQ-029 Starvation counter SHALL be sub-module arb_wait_counter (inputs inc, clr; output at_max).

Verification
REQ-030 m0 write addr 0x0 wdata 0xDEADBEEF wen 4'hF, m1 idle -> m0_gnt same cycle, RAM word0=0xDEADBEEF next edge, m0_rvalid one cycle later.
REQ-031 m1 read addr 0x4 holding 0x12345678, m0 idle -> m1_gnt, next cycle m1_rvalid=1 and m1_rdata=0x12345678.
REQ-032 Both request continuously, HOLD_MAX=4 -> m0 granted 4 cycles, m1 granted cycle 5, pattern repeats; gnt never both high.
REQ-033 m0 write wen 4'b0010 data 0x0000AB00 to word holding 0x11223344 -> word becomes 0x1122AB44.
REQ-034 rst_n pulsed to 1 during m0 write of 0xCAFEF00D -> ram_wen=0, memory unchanged, all rvalid 0, rdata 0.
REQ-035 m1_req dropped after 2 denied cycles then reasserted -> wait_cnt restarts at 0, forced grant after 4 further denials.

Source files
------------

// File: rtl/ram_arb_pkg.sv
//------------------------------------------------------------------------------
// Module  : ram_arb_pkg
// Purpose : Shared definitions for the two-master RAM arbiter: grant-select
//           encoding and the legal upper limit of the starvation hold count.
// Ports   : none (package)
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package ram_arb_pkg;

  // Which requester (if any) owns the RAM this cycle
  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_M0   = 2'd1,
    SEL_M1   = 2'd2
  } sel_e;

  // HOLD_MAX is legal in 1..HOLD_MAX_LIMIT
  localparam int HOLD_MAX_MIN   = 1;
  localparam int HOLD_MAX_LIMIT = 15;

  // Counter wide enough for any legal HOLD_MAX
  localparam int WAIT_W = $clog2(HOLD_MAX_LIMIT + 1);

endpackage

`default_nettype wire

// File: rtl/ram_arbiter_if.sv
//------------------------------------------------------------------------------
// Module  : ram_arbiter_if
// Purpose : Bundles both requester handshakes and the shared RAM port.
// Ports   : mX_req/addr/wdata/wen   requester command (X = 0 CPU, 1 loader)
//           mX_gnt/rvalid/rdata     arbiter response to requester X
//           ram_addr/wdata/wen      muxed command to the shared RAM
//           ram_rdata               combinational RAM read data
//           modport slave  : arbiter side
//           modport master : requesters + RAM side
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface ram_arbiter_if;
  logic        m0_req;
  logic [31:0] m0_addr;
  logic [31:0] m0_wdata;
  logic [3:0]  m0_wen;
  logic        m0_gnt;
  logic        m0_rvalid;
  logic [31:0] m0_rdata;

  logic        m1_req;
  logic [31:0] m1_addr;
  logic [31:0] m1_wdata;
  logic [3:0]  m1_wen;
  logic        m1_gnt;
  logic        m1_rvalid;
  logic [31:0] m1_rdata;

  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [3:0]  ram_wen;
  logic [31:0] ram_rdata;

  modport slave (
    input  m0_req, m0_addr, m0_wdata, m0_wen,
    input  m1_req, m1_addr, m1_wdata, m1_wen,
    input  ram_rdata,
    output m0_gnt, m0_rvalid, m0_rdata,
    output m1_gnt, m1_rvalid, m1_rdata,
    output ram_addr, ram_wdata, ram_wen
  );

  modport master (
    output m0_req, m0_addr, m0_wdata, m0_wen,
    output m1_req, m1_addr, m1_wdata, m1_wen,
    output ram_rdata,
    input  m0_gnt, m0_rvalid, m0_rdata,
    input  m1_gnt, m1_rvalid, m1_rdata,
    input  ram_addr, ram_wdata, ram_wen
  );
endinterface

`default_nettype wire

// File: rtl/arb_wait_counter.sv
//------------------------------------------------------------------------------
// Module  : arb_wait_counter
// Purpose : Counts consecutive denied cycles of the low-priority requester,
//           saturating at HOLD_MAX.
// Ports   : clk    clock
//           rst_n  asynchronous reset, active-high
//           inc    requester asked and was denied this cycle
//           clr    requester granted or idle this cycle
//           at_max count has reached HOLD_MAX (forces next grant)
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module arb_wait_counter
  import ram_arb_pkg::*;
#(
  parameter int HOLD_MAX = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic at_max
);

  logic [WAIT_W-1:0] cnt;

  assign at_max = (cnt == WAIT_W'(HOLD_MAX));

  // Clear wins over increment; hold at HOLD_MAX once reached
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !at_max) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/ram_arbiter.sv
//------------------------------------------------------------------------------
// Module  : ram_arbiter
// Purpose : Two-master arbiter for a single-port RAM with combinational read.
//           m0 has fixed priority; m1 is guaranteed a slot after HOLD_MAX
//           consecutive denials. Grant is same-cycle, response one cycle later.
// Ports   : clk    clock, rising edge
//           rst_n  asynchronous reset, active-high (gates grants immediately)
//           bus    ram_arbiter_if.slave - both requesters and the RAM port
// Params  : HOLD_MAX  max consecutive m1 denials, 1..15
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int HOLD_MAX = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  ram_arbiter_if.slave  bus
);

  sel_e sel;
  logic at_max;
  logic wait_inc;
  logic wait_clr;

  // Grant decision. Reset suppresses every grant combinationally so no RAM
  // write can commit while reset is held.
  always_comb begin
    sel = SEL_NONE;
    if (!rst_n) begin
      if (bus.m1_req && (!bus.m0_req || at_max)) begin
        sel = SEL_M1;
      end else if (bus.m0_req) begin
        sel = SEL_M0;
      end
    end
  end

  assign bus.m0_gnt = (sel == SEL_M0);
  assign bus.m1_gnt = (sel == SEL_M1);

  // RAM command mux; idle bus is all-zero
  always_comb begin
    bus.ram_addr  = '0;
    bus.ram_wdata = '0;
    bus.ram_wen   = '0;
    unique case (sel)
      SEL_M0: begin
        bus.ram_addr  = bus.m0_addr;
        bus.ram_wdata = bus.m0_wdata;
        bus.ram_wen   = bus.m0_wen;
      end
      SEL_M1: begin
        bus.ram_addr  = bus.m1_addr;
        bus.ram_wdata = bus.m1_wdata;
        bus.ram_wen   = bus.m1_wen;
      end
      default: ;
    endcase
  end

  // Starvation tracking: a dropped request forgets its accumulated wait
  assign wait_inc = bus.m1_req && (sel != SEL_M1);
  assign wait_clr = !bus.m1_req || (sel == SEL_M1);

  arb_wait_counter #(
    .HOLD_MAX (HOLD_MAX)
  ) u_wait_counter (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc    (wait_inc),
    .clr    (wait_clr),
    .at_max (at_max)
  );

  // Response path: rvalid follows every grant; rdata captures only on reads
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      bus.m0_rvalid <= 1'b0;
      bus.m1_rvalid <= 1'b0;
      bus.m0_rdata  <= '0;
      bus.m1_rdata  <= '0;
    end else begin
      bus.m0_rvalid <= (sel == SEL_M0);
      bus.m1_rvalid <= (sel == SEL_M1);
      if ((sel == SEL_M0) && (bus.m0_wen == 4'h0)) begin
        bus.m0_rdata <= bus.ram_rdata;
      end
      if ((sel == SEL_M1) && (bus.m1_wen == 4'h0)) begin
        bus.m1_rdata <= bus.ram_rdata;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ram_arbiter.sv
//------------------------------------------------------------------------------
// Module  : tb_ram_arbiter
// Purpose : Self-checking bench for ram_arbiter. Directed scenarios followed
//           by randomized traffic, all compared against a behavioural model
//           (fairness rule + word-array memory) kept in the bench.
// Ports   : none
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_ram_arbiter;

  localparam int H = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic mem_clr;

  always #5 clk = ~clk;

  ram_arbiter_if bus ();

  ram_arbiter #(
    .HOLD_MAX (H)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Shared RAM: 16 words, combinational read, byte-enabled write on the edge
  logic [31:0] mem [16];

  assign bus.ram_rdata = mem[bus.ram_addr[5:2]];

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 16; i++) mem[i] <= '0;
    end else begin
      for (int b = 0; b < 4; b++)
        if (bus.ram_wen[b]) mem[bus.ram_addr[5:2]][8*b +: 8] <= bus.ram_wdata[8*b +: 8];
    end
  end

  // Reference model state
  logic [31:0] model_mem [16];
  int          streak;          // consecutive cycles m1 has been refused
  logic        exp_rv0, exp_rv1;
  logic [31:0] exp_rd0, exp_rd1;
  logic        g0, g1;          // expected grants for the current cycle

  int passed = 0;
  int total  = 0;
  int fails  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data,
                                        input logic [3:0] wen);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (wen[b]) r[8*b +: 8] = data[8*b +: 8];
    return r;
  endfunction

  // One clock cycle: inputs were set at the preceding falling edge.
  task automatic step(input string tag);
    logic [31:0] ea, ed;
    logic [3:0]  ew;
    #1;
    g1 = !rst_n && bus.m1_req && (!bus.m0_req || streak == H);
    g0 = !rst_n && bus.m0_req && !g1;
    if (rst_n) begin
      exp_rv0 = 1'b0; exp_rv1 = 1'b0;
      exp_rd0 = '0;   exp_rd1 = '0;
      streak  = 0;
    end
    ea = '0; ed = '0; ew = '0;
    if (g0) begin ea = bus.m0_addr; ed = bus.m0_wdata; ew = bus.m0_wen; end
    if (g1) begin ea = bus.m1_addr; ed = bus.m1_wdata; ew = bus.m1_wen; end
    chk({tag, "_gnt0"}, 32'(bus.m0_gnt), 32'(g0));
    chk({tag, "_gnt1"}, 32'(bus.m1_gnt), 32'(g1));
    chk({tag, "_ram_wen"}, 32'(bus.ram_wen), 32'(ew));
    chk({tag, "_ram_addr"}, bus.ram_addr, ea);
    chk({tag, "_ram_wdata"}, bus.ram_wdata, ed);
    if (rst_n) begin
      chk({tag, "_rst_rv0"}, 32'(bus.m0_rvalid), 32'h0);
      chk({tag, "_rst_rv1"}, 32'(bus.m1_rvalid), 32'h0);
      chk({tag, "_rst_rd0"}, bus.m0_rdata, 32'h0);
      chk({tag, "_rst_rd1"}, bus.m1_rdata, 32'h0);
    end
    @(posedge clk);
    if (!rst_n) begin
      if (g0) begin
        if (bus.m0_wen == 4'h0) exp_rd0 = model_mem[bus.m0_addr[5:2]];
        else model_mem[bus.m0_addr[5:2]] = merge(model_mem[bus.m0_addr[5:2]], bus.m0_wdata, bus.m0_wen);
      end
      if (g1) begin
        if (bus.m1_wen == 4'h0) exp_rd1 = model_mem[bus.m1_addr[5:2]];
        else model_mem[bus.m1_addr[5:2]] = merge(model_mem[bus.m1_addr[5:2]], bus.m1_wdata, bus.m1_wen);
      end
      exp_rv0 = g0;
      exp_rv1 = g1;
      streak  = (bus.m1_req && !g1) ? ((streak + 1 > H) ? H : streak + 1) : 0;
    end
    @(negedge clk);
    chk({tag, "_rv0"}, 32'(bus.m0_rvalid), 32'(exp_rv0));
    chk({tag, "_rv1"}, 32'(bus.m1_rvalid), 32'(exp_rv1));
    chk({tag, "_rd0"}, bus.m0_rdata, exp_rd0);
    chk({tag, "_rd1"}, bus.m1_rdata, exp_rd1);
  endtask

  task automatic drive0(input logic req, input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
    bus.m0_req = req; bus.m0_addr = a; bus.m0_wdata = d; bus.m0_wen = w;
  endtask

  task automatic drive1(input logic req, input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
    bus.m1_req = req; bus.m1_addr = a; bus.m1_wdata = d; bus.m1_wen = w;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic p0, p1;
    for (int i = 0; i < 16; i++) model_mem[i] = '0;
    streak = 0;
    exp_rv0 = 1'b0; exp_rv1 = 1'b0; exp_rd0 = '0; exp_rd1 = '0;

    // Reset held with both masters requesting writes: nothing may be granted
    rst_n   = 1'b1;
    mem_clr = 1'b1;
    drive0(1'b1, 32'h0, 32'hCAFEF00D, 4'hF);
    drive1(1'b1, 32'h4, 32'h55555555, 4'hF);
    @(negedge clk);
    step("reset");
    mem_clr = 1'b0;
    rst_n   = 1'b0;
    drive0(1'b0, 32'h0, 32'h0, 4'h0);
    drive1(1'b0, 32'h0, 32'h0, 4'h0);
    step("idle");

    // m0 full-word write, m1 idle
    drive0(1'b1, 32'h0, 32'hDEADBEEF, 4'hF);
    step("m0_write");
    drive0(1'b0, 32'h0, 32'h0, 4'h0);
    chk("word0_after_write", mem[0], 32'hDEADBEEF);
    step("m0_write_resp");

    // m1 loads word 1, then reads it back
    drive1(1'b1, 32'h4, 32'h12345678, 4'hF);
    step("m1_load");
    drive1(1'b1, 32'h4, 32'h0, 4'h0);
    step("m1_read");
    chk("m1_read_data", bus.m1_rdata, 32'h12345678);
    drive1(1'b0, 32'h0, 32'h0, 4'h0);
    step("m1_idle");

    // Byte-lane write into 0x11223344
    drive0(1'b1, 32'h8, 32'h11223344, 4'hF);
    step("m0_fill");
    drive0(1'b1, 32'h8, 32'h0000AB00, 4'b0010);
    step("m0_byte");
    drive0(1'b0, 32'h0, 32'h0, 4'h0);
    chk("byte_lane_merge", mem[2], 32'h1122AB44);
    step("byte_idle");

    // Both masters continuously reading: m1 gets every fifth slot
    drive0(1'b1, 32'h0, 32'h0, 4'h0);
    drive1(1'b1, 32'h4, 32'h0, 4'h0);
    for (int c = 0; c < 10; c++) begin
      step("contend");
      chk("contend_slot_m1", 32'(bus.m1_rvalid), 32'((c % 5) == 4));
    end
    drive0(1'b0, 32'h0, 32'h0, 4'h0);
    drive1(1'b0, 32'h0, 32'h0, 4'h0);
    step("contend_idle");

    // m1 denied twice, drops, reasserts: four more denials before its slot
    drive0(1'b1, 32'h8, 32'h0, 4'h0);
    drive1(1'b1, 32'h4, 32'h0, 4'h0);
    step("cancel_deny1");
    step("cancel_deny2");
    drive1(1'b0, 32'h4, 32'h0, 4'h0);
    step("cancel_drop");
    drive1(1'b1, 32'h4, 32'h0, 4'h0);
    for (int c = 0; c < 5; c++) begin
      step("cancel_retry");
      chk("cancel_retry_slot", 32'(bus.m1_rvalid), 32'(c == 4));
    end
    drive0(1'b0, 32'h0, 32'h0, 4'h0);
    drive1(1'b0, 32'h0, 32'h0, 4'h0);
    step("cancel_idle");

    // Reset asserted while m0 presents a write: write must not land
    drive0(1'b1, 32'hC, 32'hCAFEF00D, 4'hF);
    rst_n = 1'b1;
    step("rst_mid_write");
    chk("rst_mid_word3", mem[3], 32'h0);
    rst_n = 1'b0;
    drive0(1'b0, 32'h0, 32'h0, 4'h0);
    step("rst_release");
    chk("rst_release_word3", mem[3], 32'h0);

    // Randomized traffic: requesters hold their command until granted,
    // and occasionally give up while waiting
    p0 = 1'b0;
    p1 = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (p0 && $urandom_range(0, 7) == 0) p0 = 1'b0;
      else if (!p0 && $urandom_range(0, 3) != 0) begin
        p0 = 1'b1;
        drive0(1'b1, {26'h0, 4'($urandom_range(0, 15)), 2'b00}, $urandom,
               ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0);
      end
      if (p1 && $urandom_range(0, 9) == 0) p1 = 1'b0;
      else if (!p1 && $urandom_range(0, 2) != 0) begin
        p1 = 1'b1;
        drive1(1'b1, {26'h0, 4'($urandom_range(0, 15)), 2'b00}, $urandom,
               ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0);
      end
      bus.m0_req = p0;
      bus.m1_req = p1;
      step("rand");
      if (g0) p0 = 1'b0;
      if (g1) p1 = 1'b0;
    end
    drive0(1'b0, 32'h0, 32'h0, 4'h0);
    drive1(1'b0, 32'h0, 32'h0, 4'h0);
    step("final_idle");

    for (int i = 0; i < 16; i++) chk($sformatf("mem_word%0d", i), mem[i], model_mem[i]);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
